control_seq: RTL and testbench

Multi-cycle control sequencer for the datapath. It accepts one instruction (format, opcode, sign) per handshake and steps it through DECODE, optional MEM wait, and WB, holding the decoded control lines stable for the whole instruction. It arbitrates the memory request/acknowledge handshake, pulses register write and PC enable at retire, counts retired instructions, and parks in a sticky HALTED state. It sits between the instruction fetch stage and the register file, ALU and memory.

---
 rtl/control_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_control_seq.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// control_seq: multi-cycle instruction sequencer FETCH/DECODE/MEM/WB/HALTED.
// Optional MEM wait timeout is enabled by defining CTRL_MEM_TIMEOUT_EN.
module control_seq #(
  parameter int OPCODE_W    = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                format,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                sign,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          write_src,
  output logic                reg_write,
  output logic                cpin,
  output logic                cpout,
  output logic                branch,
  output logic                jump,
  output logic                sign_out,
  output logic                pc_en,
  output logic                halt,
  output logic                mem_err,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    FETCH, DECODE, MEM, WB, HALTED
  } state_t;

  localparam logic [1:0] SRC_ALU = 2'b11;
  localparam logic [1:0] SRC_MEM = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;

  if (OPCODE_W < 4) begin : g_bad_opw
    $error("OPCODE_W must be >= 4");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_to
    $error("TIMEOUT_CYC must be >= 1");
  end

  state_t state, nxt;

  logic [1:0] d_src, src_q;
  logic d_wr, d_rd, d_wt, d_jmp, d_br;
  logic d_ci, d_co, d_mem, d_hlt;
  logic wr_q, rd_q, wt_q, jmp_q, br_q;
  logic ci_q, co_q, mem_q, hlt_q, sign_q;
  logic [CNT_W-1:0] ret_q;
  logic upper;
  logic accept;
  logic to_hit;

  assign accept = (state == FETCH) && instr_valid;
  assign upper  = (opcode >> 4) != '0;

  // Decode the incoming instruction so controls are stable from DECODE on
  always_comb begin
    d_src = SRC_MEM;
    d_wr  = 1'b0;
    d_rd  = 1'b0;
    d_wt  = 1'b0;
    d_jmp = 1'b0;
    d_br  = 1'b0;
    d_ci  = 1'b0;
    d_co  = 1'b0;
    d_mem = 1'b0;
    d_hlt = 1'b0;
    if (!format || upper) begin
      d_src = SRC_IMM;
      d_wr  = 1'b1;
    end else begin
      case (opcode[3:0])
        4'b0000, 4'b0101, 4'b1010: begin
          d_src = SRC_ALU;
          d_wr  = 1'b1;
        end
        4'b0001: begin
          d_rd  = 1'b1;
          d_mem = 1'b1;
          d_wr  = 1'b1;
        end
        4'b0010: begin
          d_wt  = 1'b1;
          d_mem = 1'b1;
        end
        4'b0011: d_jmp = 1'b1;
        4'b0100: d_br  = 1'b1;
        4'b0111: begin
          d_co = sign;
          d_ci = ~sign;
        end
        4'b1011: d_hlt = 1'b1;
        default: begin
          d_src = SRC_IMM;
          d_wr  = 1'b1;
        end
      endcase
    end
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;

  assign to_hit = (tcnt == TW'(TIMEOUT_CYC - 1)) && !mem_ack;

  // Count consecutive MEM cycles without ack; latch sticky error on expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else if (state == MEM) begin
      tcnt <= tcnt + TW'(1);
      if (to_hit) err_q <= 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  assign mem_err = err_q;
`else
  assign to_hit  = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      FETCH:  if (instr_valid) nxt = DECODE;
      DECODE: begin
        if (hlt_q)      nxt = HALTED;
        else if (mem_q) nxt = MEM;
        else            nxt = WB;
      end
      MEM: begin
        if (mem_ack)     nxt = WB;
        else if (to_hit) nxt = HALTED;
      end
      WB:      nxt = FETCH;
      HALTED:  nxt = HALTED;
      default: nxt = FETCH;
    endcase
  end

  // Control lines load on accept and clear when the instruction ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= SRC_MEM;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      wt_q   <= 1'b0;
      jmp_q  <= 1'b0;
      br_q   <= 1'b0;
      ci_q   <= 1'b0;
      co_q   <= 1'b0;
      mem_q  <= 1'b0;
      hlt_q  <= 1'b0;
      sign_q <= 1'b0;
    end else if (accept) begin
      src_q  <= d_src;
      wr_q   <= d_wr;
      rd_q   <= d_rd;
      wt_q   <= d_wt;
      jmp_q  <= d_jmp;
      br_q   <= d_br;
      ci_q   <= d_ci;
      co_q   <= d_co;
      mem_q  <= d_mem;
      hlt_q  <= d_hlt;
      sign_q <= sign;
    end else if (state == WB || nxt == HALTED) begin
      src_q <= SRC_MEM;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      wt_q  <= 1'b0;
      jmp_q <= 1'b0;
      br_q  <= 1'b0;
      ci_q  <= 1'b0;
      co_q  <= 1'b0;
      mem_q <= 1'b0;
      hlt_q <= 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            ret_q <= '0;
    else if (state == WB) ret_q <= ret_q + CNT_W'(1);
  end

  // Ready is masked while reset is held so nothing is accepted early
  assign instr_ready = (state == FETCH) && !reset;
  assign mem_req     = (state == MEM);
  assign mem_read    = rd_q;
  assign mem_write   = wt_q;
  assign write_src   = src_q;
  assign reg_write   = (state == WB) && wr_q;
  assign pc_en       = (state == WB);
  assign halt        = (state == HALTED);
  assign cpin        = ci_q;
  assign cpout       = co_q;
  assign branch      = br_q;
  assign jump        = jmp_q;
  assign sign_out    = sign_q;
  assign retired     = ret_q;

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed bench for control_seq.
// Built with CNT_W=2 and TIMEOUT_CYC=4.
module tb_control_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       format = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       sign = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_read, mem_write;
  logic [1:0] write_src;
  logic       reg_write, cpin, cpout, branch, jump;
  logic       sign_out, pc_en, halt, mem_err;
  logic [1:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  control_seq #(
    .OPCODE_W(4), .CNT_W(2), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .format(format), .opcode(opcode),
    .sign(sign), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_read(mem_read),
    .mem_write(mem_write),
    .write_src(write_src),
    .reg_write(reg_write), .cpin(cpin),
    .cpout(cpout), .branch(branch),
    .jump(jump), .sign_out(sign_out),
    .pc_en(pc_en), .halt(halt),
    .mem_err(mem_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    #1;
    n_cmp++;
    if ({instr_ready, mem_req, reg_write, pc_en, halt,
         mem_err, write_src, retired} !== 10'b0) begin
      n_err++;
      $display("FAIL rst_outs got=%b want=0",
        {instr_ready, mem_req, reg_write, pc_en, halt,
         mem_err, write_src, retired});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (instr_ready !== 1'b1 || retired !== 2'd0) begin
      n_err++;
      $display("FAIL rst_release rdy=%b ret=%0d want 1/0",
        instr_ready, retired);
    end
  endtask

  task automatic issue(input logic f, input logic [3:0] op,
                       input logic s);
    format = f;
    opcode = op;
    sign = s;
    instr_valid = 1'b1;
  endtask

  task automatic test_add();
    do_reset();
    issue(1'b1, 4'b0000, 1'b0);
    step();
    n_cmp++;
    if (write_src !== 2'b11 || reg_write !== 1'b0 ||
        instr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL add_c1 src=%b rw=%b rdy=%b want 11/0/0",
        write_src, reg_write, instr_ready);
    end
    step();
    n_cmp++;
    if (reg_write !== 1'b1 || pc_en !== 1'b1 ||
        write_src !== 2'b11) begin
      n_err++;
      $display("FAIL add_c2 rw=%b pc=%b src=%b want 1/1/11",
        reg_write, pc_en, write_src);
    end
    step();
    n_cmp++;
    if (retired !== 2'd1 || instr_ready !== 1'b1 ||
        reg_write !== 1'b0 || pc_en !== 1'b0) begin
      n_err++;
      $display("FAIL add_c3 ret=%0d rdy=%b rw=%b pc=%b want 1/1/0/0",
        retired, instr_ready, reg_write, pc_en);
    end
    instr_valid = 1'b0;
  endtask

  task automatic run_mem(input logic [3:0] op, input int waits,
                         input logic exp_rw, input logic exp_rd);
    int n = 0;
    int bad = 0;
    issue(1'b1, op, 1'b0);
    step();
    instr_valid = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_read !== exp_rd ||
        mem_write !== !exp_rd || write_src !== 2'b00) begin
      n_err++;
      $display("FAIL mem_dec req=%b rd=%b wt=%b src=%b want 0/%b/%b/00",
        mem_req, mem_read, mem_write, write_src, exp_rd, !exp_rd);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 20 && mem_req === 1'b1; i++) begin
      n++;
      if (mem_read !== exp_rd || mem_write !== !exp_rd) bad++;
      if (n == waits + 1) mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    n_cmp++;
    if (n != waits + 1 || bad != 0) begin
      n_err++;
      $display("FAIL mem_req_len got=%0d bad=%0d want %0d/0",
        n, bad, waits + 1);
    end
    n_cmp++;
    if (reg_write !== exp_rw || pc_en !== 1'b1 ||
        mem_err !== 1'b0) begin
      n_err++;
      $display("FAIL mem_wb rw=%b pc=%b err=%b want %b/1/0",
        reg_write, pc_en, mem_err, exp_rw);
    end
    step();
  endtask

  task automatic test_load();
    do_reset();
    run_mem(4'b0001, 3, 1'b1, 1'b1);
    n_cmp++;
    if (retired !== 2'd1 || instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_ret ret=%0d rdy=%b want 1/1",
        retired, instr_ready);
    end
  endtask

  task automatic test_store();
    do_reset();
    run_mem(4'b0010, 3, 1'b0, 1'b0);
    n_cmp++;
    if (retired !== 2'd1) begin
      n_err++;
      $display("FAIL store_ret got=%0d want 1", retired);
    end
  endtask

  task automatic test_cp();
    do_reset();
    issue(1'b1, 4'b0111, 1'b1);
    step();
    instr_valid = 1'b0;
    n_cmp++;
    if (cpout !== 1'b1 || cpin !== 1'b0 || sign_out !== 1'b1) begin
      n_err++;
      $display("FAIL cp1 out=%b in=%b s=%b want 1/0/1",
        cpout, cpin, sign_out);
    end
    step();
    n_cmp++;
    if (reg_write !== 1'b0 || pc_en !== 1'b1) begin
      n_err++;
      $display("FAIL cp1_wb rw=%b pc=%b want 0/1", reg_write, pc_en);
    end
    step();
    issue(1'b1, 4'b0111, 1'b0);
    step();
    instr_valid = 1'b0;
    n_cmp++;
    if (cpin !== 1'b1 || cpout !== 1'b0 || sign_out !== 1'b0) begin
      n_err++;
      $display("FAIL cp0 in=%b out=%b s=%b want 1/0/0",
        cpin, cpout, sign_out);
    end
    step();
    step();
    n_cmp++;
    if (retired !== 2'd2) begin
      n_err++;
      $display("FAIL cp_ret got=%0d want 2", retired);
    end
  endtask

  task automatic test_jump_branch();
    do_reset();
    issue(1'b1, 4'b0011, 1'b0);
    step();
    instr_valid = 1'b0;
    n_cmp++;
    if (jump !== 1'b1 || branch !== 1'b0 || write_src !== 2'b00) begin
      n_err++;
      $display("FAIL jump j=%b b=%b src=%b want 1/0/00",
        jump, branch, write_src);
    end
    step();
    step();
    issue(1'b0, 4'b0100, 1'b0);
    step();
    instr_valid = 1'b0;
    n_cmp++;
    if (branch !== 1'b0 || write_src !== 2'b01) begin
      n_err++;
      $display("FAIL imm b=%b src=%b want 0/01", branch, write_src);
    end
    step();
    n_cmp++;
    if (reg_write !== 1'b1) begin
      n_err++;
      $display("FAIL imm_wb rw=%b want 1", reg_write);
    end
    step();
  endtask

  task automatic test_halt();
    do_reset();
    issue(1'b1, 4'b1011, 1'b0);
    step();
    instr_valid = 1'b0;
    n_cmp++;
    if (halt !== 1'b0) begin
      n_err++;
      $display("FAIL halt_dec got=%b want 0", halt);
    end
    step();
    n_cmp++;
    if (halt !== 1'b1 || instr_ready !== 1'b0 || pc_en !== 1'b0) begin
      n_err++;
      $display("FAIL halt_on h=%b rdy=%b pc=%b want 1/0/0",
        halt, instr_ready, pc_en);
    end
    issue(1'b1, 4'b0000, 1'b0);
    repeat (10) step();
    n_cmp++;
    if (halt !== 1'b1 || retired !== 2'd0 ||
        instr_ready !== 1'b0 || reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL halt_hold h=%b ret=%0d rdy=%b rw=%b want 1/0/0/0",
        halt, retired, instr_ready, reg_write);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (halt !== 1'b0) begin
      n_err++;
      $display("FAIL halt_clr got=%b want 0", halt);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(1'b1, 4'b0000, 1'b0);
    repeat (15) step();
    instr_valid = 1'b0;
    n_cmp++;
    if (retired !== 2'd1) begin
      n_err++;
      $display("FAIL wrap got=%0d want 1", retired);
    end
    step();
    step();
    step();
  endtask

  task automatic test_reset_mem();
    do_reset();
    issue(1'b1, 4'b0101, 1'b0);
    step();
    instr_valid = 1'b0;
    step();
    step();
    issue(1'b1, 4'b0001, 1'b0);
    step();
    instr_valid = 1'b0;
    step();
    n_cmp++;
    if (mem_req !== 1'b1 || retired !== 2'd1) begin
      n_err++;
      $display("FAIL rm_pre req=%b ret=%0d want 1/1", mem_req, retired);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || retired !== 2'd0 ||
        pc_en !== 1'b0 || reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL rm_async req=%b ret=%0d pc=%b rw=%b want 0/0/0/0",
        mem_req, retired, pc_en, reg_write);
    end
    do_reset();
  endtask

`ifdef CTRL_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    do_reset();
    issue(1'b1, 4'b0001, 1'b0);
    step();
    instr_valid = 1'b0;
    step();
    for (int i = 0; i < 20 && mem_req === 1'b1; i++) begin
      n++;
      step();
    end
    n_cmp++;
    if (n != 4 || halt !== 1'b1 || mem_err !== 1'b1 ||
        retired !== 2'd0 || reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL timeout n=%0d h=%b e=%b ret=%0d want 4/1/1/0",
        n, halt, mem_err, retired);
    end
    do_reset();
    n_cmp++;
    if (mem_err !== 1'b0) begin
      n_err++;
      $display("FAIL to_clr got=%b want 0", mem_err);
    end
    run_mem(4'b0001, 3, 1'b1, 1'b1);
    n_cmp++;
    if (retired !== 2'd1 || mem_err !== 1'b0 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL to_edge ret=%0d e=%b h=%b want 1/0/0",
        retired, mem_err, halt);
    end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    run_mem(4'b0001, 12, 1'b1, 1'b1);
    n_cmp++;
    if (retired !== 2'd1 || mem_err !== 1'b0 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL long_wait ret=%0d e=%b h=%b want 1/0/0",
        retired, mem_err, halt);
    end
  endtask
`endif

  initial begin
    test_add();
    test_load();
    test_store();
    test_cp();
    test_jump_branch();
    test_halt();
    test_back_to_back();
    test_reset_mem();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
